// File: rtl/adder_pkg.sv
// Shared operand/sum types for the adder and the blocks that feed it.
package adder_pkg;

    localparam int OPW = 16;

    typedef logic [OPW-1:0] operand_t;
    typedef logic [OPW:0]   sum_t;

    // One queued operand pair; a occupies the upper half when packed.
    typedef struct packed {
        operand_t a;
        operand_t b;
    } pair_t;

endpackage

// File: rtl/adder_fifo.sv
// Synchronous FIFO with asynchronous reset. Pointers carry one extra bit so
// that full and empty can be told apart when the index bits match.
module adder_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is dropped even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;
    assign rdata = mem[rptr[AW-1:0]];

    // Pointer update; both wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/adder_feeder.sv
// Feeds operand pairs to an external fixed-latency adder and collects its
// sums in order. Issue is credit-limited so that every sum in flight is
// guaranteed a slot in the result FIFO when it comes back.
module adder_feeder
    import adder_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDER_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OPW-1:0]         in_a,
    input  logic [OPW-1:0]         in_b,
    output logic [OPW-1:0]         o_a,
    output logic [OPW-1:0]         o_b,
    input  logic [OPW:0]           i_sum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OPW:0]           out_sum,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] LIMIT = DEPTH[AW+1:0];

    pair_t          in_pair;
    pair_t          head_pair;
    logic           op_full;
    logic           op_empty;
    logic [AW:0]    op_count;
    logic           push_op;

    sum_t           res_head;
    logic           res_full;
    logic           res_empty;
    logic [AW:0]    res_count;

    logic [ADDER_LAT:0] pipe;
    logic [AW:0]        inflight;
    logic [AW+1:0]      committed;
    logic               issue;
    logic               capture;

    // Handshake: a pair moves on a rising edge where in_valid && in_ready,
    // a result moves where out_valid && out_ready; neither side may make
    // its valid depend on the other side's ready.
    assign in_pair  = {in_a, in_b};
    assign in_ready = !op_full && !rst;
    assign push_op  = in_valid && in_ready;

    // Results already stored plus sums still in the adder must stay within
    // the result FIFO, otherwise a returning sum could find no room.
    assign committed = {1'b0, res_count} + {1'b0, inflight};
    assign issue     = !op_empty && (committed < LIMIT);
    assign capture   = pipe[ADDER_LAT];

    assign out_valid = !res_empty;
    assign out_sum   = out_valid ? res_head : '0;
    assign level     = op_count;

    adder_fifo #(
        .WIDTH ($bits(pair_t)),
        .DEPTH (DEPTH)
    ) u_op_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_op),
        .wdata (in_pair),
        .pop   (issue),
        .rdata (head_pair),
        .full  (op_full),
        .empty (op_empty),
        .count (op_count)
    );

    adder_fifo #(
        .WIDTH ($bits(sum_t)),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .wdata (i_sum),
        .pop   (out_ready),
        .rdata (res_head),
        .full  (res_full),
        .empty (res_empty),
        .count (res_count)
    );

    // Valid pipe: a tag tracks each issued pair until its sum is due on i_sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= issue;
            for (int i = 1; i <= ADDER_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Count of tags in the pipe; issue and capture together cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue, capture})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Operand registers toward the adder; zero whenever nothing is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_a <= '0;
            o_b <= '0;
        end else if (issue) begin
            o_a <= head_pair.a;
            o_b <= head_pair.b;
        end else begin
            o_a <= '0;
            o_b <= '0;
        end
    end

    // The credit scheme must make a capture into a full result FIFO impossible.
    assert property (@(posedge clk) disable iff (rst) capture |-> !res_full);

endmodule

// File: tb/tb_adder_feeder.sv
// Directed bench for adder_feeder with a one-cycle behavioural adder.
module tb_adder_feeder;

    localparam int DEPTH = 4;
    localparam int LAT   = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [15:0] o_a;
    logic [15:0] o_b;
    logic [16:0] i_sum;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [16:0] out_sum;
    logic [2:0]  level;

    logic [16:0] adder_sum = '0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int stream_drop = 0;
    bit stream_mode = 1'b0;

    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    int          got_cyc[$];

    adder_feeder #(.DEPTH(DEPTH), .ADDER_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .o_a       (o_a),
        .o_b       (o_b),
        .i_sum     (i_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .level     (level)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream adder: samples o_a/o_b each edge, sum valid one cycle later.
    always @(posedge clk) adder_sum <= {1'b0, o_a} + {1'b0, o_b};
    assign i_sum = adder_sum;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) tick();
        tick();
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: record accepted pairs, compare each consumed result in order.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
            if (out_valid && out_ready) begin
                got_q.push_back(out_sum);
                got_cyc.push_back(cyc);
                if (exp_q.size() == 0) check("sb_extra_result", 32'd1, 32'd0);
                else check("sb_order", 32'(out_sum), 32'(exp_q.pop_front()));
            end
            if (stream_mode && !in_ready) stream_drop++;
        end
    end

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached with %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1);
    end

    initial begin
        // Reset state.
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_o_a", 32'(o_a), 32'd0);
        check("rst_o_b", 32'(o_b), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("ready_after_rst", 32'(in_ready), 32'd1);

        // Scenario 1: single pair, exact latency.
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_a = 16'd3;
        in_b = 16'd5;
        tick();  // edge 0: accept
        in_valid = 1'b0;
        check("s1_e0_level", 32'(level), 32'd1);
        check("s1_e0_valid", 32'(out_valid), 32'd0);
        tick();  // edge 1: issue
        check("s1_e1_o_a", 32'(o_a), 32'd3);
        check("s1_e1_o_b", 32'(o_b), 32'd5);
        check("s1_e1_level", 32'(level), 32'd0);
        tick();  // edge 2
        check("s1_e2_valid", 32'(out_valid), 32'd0);
        check("s1_e2_o_a", 32'(o_a), 32'd0);
        tick();  // edge 3: capture
        check("s1_e3_valid", 32'(out_valid), 32'd1);
        check("s1_e3_sum", 32'(out_sum), 32'd8);
        tick();  // edge 4: consumed
        check("s1_e4_valid", 32'(out_valid), 32'd0);

        // Scenario 2: carry-out.
        got_q.delete();
        send_pair(16'hFFFF, 16'hFFFF);
        send_pair(16'hFFFF, 16'h0001);
        drain("s2_drain");
        check("s2_count", 32'(got_q.size()), 32'd2);
        check("s2_sum0", 32'(got_q[0]), 32'h1FFFE);
        check("s2_sum1", 32'(got_q[1]), 32'h10000);

        // Scenario 3: 16 back-to-back pairs.
        got_q.delete();
        got_cyc.delete();
        stream_mode = 1'b1;
        for (int i = 0; i < 16; i++) send_pair(16'(i), 16'(2 * i));
        stream_mode = 1'b0;
        drain("s3_drain");
        check("s3_count", 32'(got_q.size()), 32'd16);
        check("s3_ready_drop", 32'(stream_drop), 32'd0);
        for (int i = 0; i < 16; i++) check("s3_sum", 32'(got_q[i]), 32'(3 * i));
        for (int i = 1; i < 16; i++) check("s3_gap", 32'(got_cyc[i] - got_cyc[i-1]), 32'd1);

        // Scenario 4: back-pressure with 10 pairs offered.
        got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_pair(16'(100 + i), 16'(1000 + i));
        in_valid = 1'b1;
        in_a = 16'd108;
        in_b = 16'd1008;
        tick();
        tick();
        tick();
        check("s4_in_ready", 32'(in_ready), 32'd0);
        check("s4_level", 32'(level), 32'd4);
        check("s4_o_a", 32'(o_a), 32'd0);
        check("s4_o_b", 32'(o_b), 32'd0);
        check("s4_valid", 32'(out_valid), 32'd1);
        check("s4_head", 32'(out_sum), 32'd1100);
        tick();
        check("s4_head_stable", 32'(out_sum), 32'd1100);
        check("s4_o_a_idle", 32'(o_a), 32'd0);
        out_ready = 1'b1;
        send_pair(16'd108, 16'd1008);
        send_pair(16'd109, 16'd1009);
        drain("s4_drain");
        check("s4_count", 32'(got_q.size()), 32'd10);
        check("s4_first", 32'(got_q[0]), 32'd1100);
        check("s4_last", 32'(got_q[9]), 32'd1118);

        // Scenario 6: full operand FIFO, pop and push in the same cycle.
        got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_pair(16'(200 + i), 16'(300 + i));
        in_valid = 1'b1;
        in_a = 16'd50;
        in_b = 16'd60;
        tick();
        check("s6_full_level", 32'(level), 32'd4);
        check("s6_full_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();  // one result consumed, frees one credit
        out_ready = 1'b0;
        check("s6_pop_level", 32'(level), 32'd4);
        tick();  // operand popped while the push is refused
        check("s6_refused_level", 32'(level), 32'd3);
        check("s6_ready_back", 32'(in_ready), 32'd1);
        tick();  // pending pair now accepted
        in_valid = 1'b0;
        check("s6_refill_level", 32'(level), 32'd4);
        out_ready = 1'b1;
        drain("s6_drain");
        check("s6_count", 32'(got_q.size()), 32'd9);
        check("s6_last", 32'(got_q[8]), 32'd110);

        // Scenario 5: reset with pairs queued and in flight.
        got_q.delete();
        out_ready = 1'b0;
        send_pair(16'd1, 16'd1);
        send_pair(16'd2, 16'd2);
        tick();
        tick();
        tick();
        tick();
        for (int i = 0; i < 4; i++) send_pair(16'(10 + i), 16'(10 + i));
        check("s5_pre_level", 32'(level), 32'd2);
        rst = 1'b1;
        #1;
        check("s5_rst_in_ready", 32'(in_ready), 32'd0);
        check("s5_rst_valid", 32'(out_valid), 32'd0);
        check("s5_rst_o_a", 32'(o_a), 32'd0);
        check("s5_rst_o_b", 32'(o_b), 32'd0);
        check("s5_rst_sum", 32'(out_sum), 32'd0);
        check("s5_rst_level", 32'(level), 32'd0);
        tick();
        check("s5_hold_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("s5_no_stale", 32'(got_q.size()), 32'd0);
        send_pair(16'd7, 16'd9);
        drain("s5_drain");
        check("s5_count", 32'(got_q.size()), 32'd1);
        check("s5_sum", 32'(got_q[0]), 32'd16);

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
